// File: rtl/fetch_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_pkg                                                             |
// | Shared widths, reset PC default and queue entry type for fetch_unit. |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package fetch_pkg;

   localparam int XLEN = 64;
   localparam int ILEN = 32;
   localparam logic [XLEN-1:0] RESET_PC_DEFAULT = '0;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [ILEN-1:0] instr;
   } fetch_entry_t;

   function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
      return addr & ~{{(XLEN-2){1'b0}}, 2'b11};
   endfunction

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_queue                                                           |
// | Synchronous FIFO of {pc, instr} entries with flush; power-of-2 depth.|
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int QDEPTH = 2
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      i_flush,
   input  logic                      i_push,
   input  fetch_entry_t              i_push_data,
   input  logic                      i_pop,
   output logic [$clog2(QDEPTH):0]   o_count,
   output logic                      o_valid,
   output fetch_entry_t              o_head
);

   localparam int PW = $clog2(QDEPTH);

   fetch_entry_t    r_mem [QDEPTH];
   logic [PW-1:0]   r_wr_ptr;
   logic [PW-1:0]   r_rd_ptr;
   logic [PW:0]     r_count;
   logic            w_push;
   logic            w_pop;

   // Flush wins over both push and pop in the same cycle.
   assign w_push = i_push & ~i_flush;
   assign w_pop  = i_pop & ~i_flush & (r_count != '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PW'(1);
         end
         unique case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (PW+1)'(1);
            2'b01:   r_count <= r_count - (PW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   for (genvar gi = 0; gi < QDEPTH; gi++) begin : g_mem
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_mem[gi] <= '0;
         end else if (w_push && (r_wr_ptr == PW'(gi))) begin
            r_mem[gi] <= i_push_data;
         end
      end
   end

   assign o_count = r_count;
   assign o_valid = (r_count != '0);
   assign o_head  = r_mem[r_rd_ptr];

endmodule : fetch_queue
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_unit                                                            |
// | Instruction fetch: PC, imem req/gnt/rvalid, fetch queue, redirect.   |
// | Optional perf counters when FETCH_PERF_CNT_EN is defined.            |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int              QDEPTH   = 2,
   parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_redirect_valid,
   input  logic [XLEN-1:0]  i_redirect_pc,
   output logic             o_imem_req,
   output logic [XLEN-1:0]  o_imem_addr,
   input  logic             i_imem_gnt,
   input  logic             i_imem_rvalid,
   input  logic [ILEN-1:0]  i_imem_rdata,
   output logic             o_id_valid,
   input  logic             i_id_ready,
   output logic [XLEN-1:0]  o_id_pc,
   output logic [ILEN-1:0]  o_id_instr
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]      o_perf_fetched,
   output logic [31:0]      o_perf_flushed
`endif
);

   localparam int CW = $clog2(QDEPTH) + 1;

   logic [XLEN-1:0] r_pc;
   logic            r_hold;
   logic            r_hold_stale;
   logic [XLEN-1:0] r_hold_addr;
   logic            r_outstanding;
   logic            r_discard;
   logic [XLEN-1:0] r_tag_pc;

   logic [CW-1:0]   w_count;
   logic            w_q_valid;
   fetch_entry_t    w_head;
   fetch_entry_t    w_push_data;
   logic            w_pop;
   logic            w_push;
   logic [CW:0]     w_used;
   logic            w_req_new;
   logic            w_grant;
   logic            w_grant_stale;

   // A pop already accepted this cycle frees its slot for a new request,
   // which is what sustains one instruction per cycle at QDEPTH=2.
   assign w_pop  = w_q_valid & i_id_ready & ~i_redirect_valid;
   assign w_used = {1'b0, w_count} + {{CW{1'b0}}, r_outstanding} - {{CW{1'b0}}, w_pop};

   assign w_req_new = rst_n & ~i_redirect_valid
                    & (~r_outstanding | i_imem_rvalid)
                    & (w_used < (CW+1)'(QDEPTH));

   assign o_imem_req  = r_hold | w_req_new;
   assign o_imem_addr = r_hold ? r_hold_addr : r_pc;
   assign w_grant     = o_imem_req & i_imem_gnt;

   // A held request whose address predates a redirect fetches dead code.
   assign w_grant_stale = r_hold & (r_hold_stale | i_redirect_valid);

   assign w_push = i_imem_rvalid & r_outstanding & ~r_discard & ~i_redirect_valid;

   always_comb begin
      w_push_data       = '0;
      w_push_data.pc    = r_tag_pc;
      w_push_data.instr = i_imem_rdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc          <= RESET_PC;
         r_hold        <= 1'b0;
         r_hold_stale  <= 1'b0;
         r_hold_addr   <= '0;
         r_outstanding <= 1'b0;
         r_discard     <= 1'b0;
         r_tag_pc      <= '0;
      end else begin
         if (i_redirect_valid) begin
            r_pc <= word_align(i_redirect_pc);
         end else if (w_grant && !(r_hold && r_hold_stale)) begin
            r_pc <= r_pc + XLEN'(4);
         end

         if (w_grant) begin
            r_hold       <= 1'b0;
            r_hold_stale <= 1'b0;
         end else if (o_imem_req) begin
            r_hold       <= 1'b1;
            r_hold_addr  <= o_imem_addr;
            r_hold_stale <= r_hold_stale | (r_hold & i_redirect_valid);
         end

         if (w_grant) begin
            r_outstanding <= 1'b1;
            r_tag_pc      <= o_imem_addr;
            r_discard     <= w_grant_stale;
         end else if (i_imem_rvalid) begin
            r_outstanding <= 1'b0;
            r_discard     <= 1'b0;
         end else if (i_redirect_valid && r_outstanding) begin
            r_discard     <= 1'b1;
         end
      end
   end

   fetch_queue #(
      .QDEPTH (QDEPTH)
   ) u_queue (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_flush     (i_redirect_valid),
      .i_push      (w_push),
      .i_push_data (w_push_data),
      .i_pop       (w_pop),
      .o_count     (w_count),
      .o_valid     (w_q_valid),
      .o_head      (w_head)
   );

   assign o_id_valid = w_q_valid;
   assign o_id_pc    = w_head.pc;
   assign o_id_instr = w_head.instr;

`ifdef FETCH_PERF_CNT_EN
   logic        w_drop;
   logic [CW:0] w_flushed;
   logic [31:0] r_perf_fetched;
   logic [31:0] r_perf_flushed;

   assign w_drop    = i_imem_rvalid & (r_discard | i_redirect_valid);
   assign w_flushed = (i_redirect_valid ? {1'b0, w_count} : '0) + {{CW{1'b0}}, w_drop};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_perf_fetched <= '0;
         r_perf_flushed <= '0;
      end else begin
         r_perf_fetched <= r_perf_fetched + 32'(w_push);
         r_perf_flushed <= r_perf_flushed + 32'(w_flushed);
      end
   end

   assign o_perf_fetched = r_perf_fetched;
   assign o_perf_flushed = r_perf_flushed;
`endif

   a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
      !(w_push && (w_count == CW'(QDEPTH))));

   a_rvalid_owned: assert property (@(posedge clk) disable iff (!rst_n)
      !(i_imem_rvalid && !r_outstanding));

endmodule : fetch_unit
`default_nettype wire
